lead_one_normalizer: RTL and testbench

Pipelined, parametrised leading-one detector and normaliser for the floating-point datapath. It counts the leading zeros of a WIDTH-bit significand and left-shifts the significand so its leading 1 lands in the MSB. A two-stage valid/ready pipeline with backpressure carries the result. It sits between the significand add/subtract stage and the exponent-adjust/round stage of the fp32 adder, and is sized for reuse in wider formats.

---
 rtl/lead_one_normalizer.sv | 166 ++++++++++++++++
 tb/tb_lead_one_normalizer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lead_one_normalizer.sv
// lead_one_normalizer
//
// Two-stage valid/ready pipeline that counts the leading zeros of a WIDTH-bit significand
// and left-shifts it so the leading 1 lands in the MSB.
//   S1: tree leading-zero count on in_sig; registers sig, lz, zero flag (and max shift).
//   S2: picks the shift, registers the shifted significand and result flags.
//
// Optional feature macro: NORM_SAT_EN
//   Defined   : shift = min(lz, in_max_shift), out_limited flags a clamped shift.
//   Undefined : shift = lz, out_limited tied 0, in_max_shift ignored.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready is combinational from out_ready
//   in_sig                significand to normalise
//   in_max_shift          largest shift allowed (exponent headroom), NORM_SAT_EN only
//   out_valid/out_ready   output handshake
//   out_sig               normalised significand
//   out_shift             shift applied
//   out_zero              input was all zeros
//   out_limited           shift was clamped by in_max_shift
module lead_one_normalizer #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sig,
    input  logic [CNT_W-1:0] in_max_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sig,
    output logic [CNT_W-1:0] out_shift,
    output logic             out_zero,
    output logic             out_limited
);

    // Leaf count of the LZC tree; input is padded at the LSB end up to this size.
    localparam int unsigned LEAVES = 1 << CNT_W;

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic             adv1, adv2;
    logic             s1_load, s2_load;

    logic [WIDTH-1:0] s1_sig_q;
    logic [CNT_W-1:0] s1_lz_q;
    logic             s1_zero_q;

    logic [WIDTH-1:0] out_sig_q, out_sig_d;
    logic [CNT_W-1:0] out_shift_q, out_shift_d;
    logic             out_zero_q;
    logic             limited_d;

    logic [LEAVES-1:0] sig_pad;
    logic [LEAVES-1:0] lzc_v;
    logic [CNT_W-1:0]  lzc_c [LEAVES];
    logic [CNT_W-1:0]  lz;
    logic              in_zero;

    // Handshake: an empty stage always accepts, so bubbles collapse.
    always_comb begin
        adv2     = !v2_q || out_ready;
        adv1     = !v1_q || adv2;
        in_ready = adv1;
        s1_load  = in_valid && adv1;
        s2_load  = v1_q && adv2;
        v1_d     = adv1 ? in_valid : v1_q;
        v2_d     = adv2 ? v1_q : v2_q;
    end

    // Low padding bits are zero, so they never change the count of a nonzero input.
    assign sig_pad = LEAVES'(in_sig) << (LEAVES - WIDTH);

    // Pairwise reduction tree, MSB-first node order. Node k at level s merges children
    // 2k (upper half) and 2k+1 (lower half); a miss in the upper half adds its size 2^s.
    // The count of node k is computed before its valid is overwritten (k may equal 2k).
    always_comb begin
        for (int k = 0; k < LEAVES; k++) begin
            lzc_v[k] = sig_pad[LEAVES-1-k];
            lzc_c[k] = '0;
        end
        for (int s = 0; s < CNT_W; s++) begin
            for (int k = 0; k < (LEAVES >> (s + 1)); k++) begin
                lzc_c[k] = lzc_v[2*k] ? lzc_c[2*k] : (lzc_c[2*k+1] | CNT_W'(1 << s));
                lzc_v[k] = lzc_v[2*k] | lzc_v[2*k+1];
            end
        end
        lz      = lzc_c[0];
        in_zero = !lzc_v[0];
    end

`ifdef NORM_SAT_EN
    logic [CNT_W-1:0] s1_max_q;
    logic             out_limited_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_max_q      <= '0;
            out_limited_q <= 1'b0;
        end else begin
            if (s1_load) s1_max_q <= in_max_shift;
            if (s2_load) out_limited_q <= limited_d;
        end
    end

    always_comb begin
        out_shift_d = s1_zero_q ? '0 : s1_lz_q;
        limited_d   = 1'b0;
        // Clamp keeps the result partially unnormalised when exponent headroom runs out.
        if (!s1_zero_q && (s1_lz_q > s1_max_q)) begin
            out_shift_d = s1_max_q;
            limited_d   = 1'b1;
        end
        out_sig_d = s1_sig_q << out_shift_d;
    end

    assign out_limited = out_limited_q;
`else
    logic unused_max_shift;
    assign unused_max_shift = ^in_max_shift;

    always_comb begin
        out_shift_d = s1_zero_q ? '0 : s1_lz_q;
        limited_d   = 1'b0;
        out_sig_d   = s1_sig_q << out_shift_d;
    end

    assign out_limited = limited_d;
`endif

    // Data registers only move on stage advance so held outputs stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s1_sig_q    <= '0;
            s1_lz_q     <= '0;
            s1_zero_q   <= 1'b0;
            out_sig_q   <= '0;
            out_shift_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            if (s1_load) begin
                s1_sig_q  <= in_sig;
                s1_lz_q   <= lz;
                s1_zero_q <= in_zero;
            end
            if (s2_load) begin
                out_sig_q   <= out_sig_d;
                out_shift_q <= out_shift_d;
                out_zero_q  <= s1_zero_q;
            end
        end
    end

    assign out_valid = v2_q;
    assign out_sig   = out_sig_q;
    assign out_shift = out_shift_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_lead_one_normalizer.sv
// Scoreboard bench for lead_one_normalizer (WIDTH=24, CNT_W=5).
// Accepted inputs push a model result; a monitor compares every presented output.
module tb_lead_one_normalizer;

    localparam int W = 24;
    localparam int C = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_sig = '0;
    logic [C-1:0] in_max_shift = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sig;
    logic [C-1:0] out_shift;
    logic         out_zero;
    logic         out_limited;

    typedef struct packed {
        logic [W-1:0] sig;
        logic [C-1:0] shift;
        logic         zero;
        logic         lim;
    } res_t;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_acc = 0;
    int   cyc = 0;
    bit   rnd_done = 0;

    lead_one_normalizer #(
        .WIDTH(W),
        .CNT_W(C)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sig       (in_sig),
        .in_max_shift (in_max_shift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sig      (out_sig),
        .out_shift    (out_shift),
        .out_zero     (out_zero),
        .out_limited  (out_limited)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: scan for the leading 1, shift by its distance from the MSB.
    function automatic res_t model(input logic [W-1:0] s, input logic [C-1:0] m);
        res_t r;
        int   lz;
        r = '0;
        if (s == '0) begin
            r.zero = 1'b1;
            return r;
        end
        lz = 0;
        while (!s[W-1-lz]) lz++;
        r.shift = C'(lz);
`ifdef NORM_SAT_EN
        if (lz > int'(m)) begin
            r.shift = m;
            r.lim   = 1'b1;
        end
`endif
        r.sig = s << r.shift;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Handshake is stable at negedge; the transfer completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(in_sig, in_max_shift));
            n_acc++;
        end
    end

    // Every cycle out_valid is high the outputs must equal the oldest pending result,
    // which also checks stability while stalled.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_output: got sig %0h with no pending result", out_sig);
            end else begin
                chk("out_sig", 64'(out_sig), 64'(exp_q[0].sig));
                chk("out_shift", 64'(out_shift), 64'(exp_q[0].shift));
                chk("out_zero", 64'(out_zero), 64'(exp_q[0].zero));
                chk("out_limited", 64'(out_limited), 64'(exp_q[0].lim));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [W-1:0] s, input logic [C-1:0] m);
        int t;
        t = 0;
        in_valid     = 1'b1;
        in_sig       = s;
        in_max_shift = m;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        logic [31:0] r;
        logic [W-1:0] s;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sig", 64'(out_sig), 64'd0);
        chk("rst_out_shift", 64'(out_shift), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_out_limited", 64'(out_limited), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First transaction and latency
        send(24'h800000, 5'd0);
        @(negedge clk);
        chk("latency_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_cycle2_valid", 64'(out_valid), 64'd1);
        drain();

        // Walking one, back-to-back: one accept per cycle
        c0 = cyc;
        for (int i = W - 1; i >= 0; i--) begin
            s = '0;
            s[i] = 1'b1;
            send(s, C'($urandom_range(0, 31)));
        end
        chk("walk_accept_cycles", 64'(cyc - c0), 64'd24);
        drain();

        // Zero input and clamp vectors
        send(24'h000000, 5'd7);
        send(24'h000100, 5'd10);
        send(24'h000100, 5'd20);
        send(24'h000001, 5'd0);
        drain();

        // Backpressure: only two accepts fit while out_ready is low
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                send(24'h400000, 5'd3);
                send(24'h002000, 5'd3);
                send(24'h000010, 5'd3);
                send(24'h123456, 5'd3);
            end
            begin
                repeat (5) @(negedge clk);
                #1;
                chk("bp_accepts", 64'(n_acc - base), 64'd2);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with the pipeline full
        out_ready = 1'b0;
        send(24'h0F0000, 5'd1);
        send(24'h00F000, 5'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_sig", 64'(out_sig), 64'd0);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_idle_valid", 64'(out_valid), 64'd0);
        send(24'h000ABC, 5'd3);
        drain();

        // Randomised traffic with random backpressure
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    r = $urandom;
                    s = r[W-1:0] >> $urandom_range(0, W);
                    if ($urandom_range(0, 15) == 0) s = '0;
                    send(s, C'($urandom_range(0, 31)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
